// File: rtl/noise_table_loader.sv
// rtl/noise_table_loader.sv - streams a dither-noise table into the noise RAM write ports
// Writes land one cycle after beat acceptance; table_valid rises only after a full, uninterrupted table.
module noise_table_loader #(
  parameter int AW = 12,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          busy,
  output logic          done,
  output logic          table_valid,
  output logic [AW:0]   load_count,
  output logic [15:0]   checksum
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [AW:0] LAST_IDX = {1'b0, {AW{1'b1}}};

  state_t state;
  logic   accept;

  // start and abort take precedence over data, so no beat is taken in those cycles.
  assign din_ready = (state == LOAD) && !start && !abort;
  assign accept    = din_valid && din_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_din     <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      table_valid <= 1'b0;
      load_count  <= '0;
      checksum    <= '0;
    end else begin
      ram_we <= 1'b0;
      done   <= 1'b0;

      if (accept) begin
        ram_we     <= 1'b1;
        ram_addr   <= load_count[AW-1:0];
        ram_din    <= din;
        load_count <= load_count + 1'b1;
        checksum   <= checksum + 16'(din);
      end

      if (start) begin
        state       <= LOAD;
        busy        <= 1'b1;
        load_count  <= '0;
        checksum    <= '0;
        table_valid <= 1'b0;
      end else if (abort && state != IDLE) begin
        state       <= IDLE;
        busy        <= 1'b0;
        table_valid <= 1'b0;
      end else begin
        case (state)
          LOAD: begin
            if (accept && load_count == LAST_IDX) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
          DONE: begin
            state       <= IDLE;
            busy        <= 1'b0;
            table_valid <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_noise_table_loader.sv
// tb/tb_noise_table_loader.sv - scoreboard bench for noise_table_loader
module tb_noise_table_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [7:0]  ram_din;
  logic        busy;
  logic        done;
  logic        table_valid;
  logic [12:0] load_count;
  logic [15:0] checksum;

  int tests = 0;
  int fails = 0;

  logic [20:0] exp_q[$];
  logic        mloading = 1'b0;
  int          mcount = 0;
  logic [15:0] mcs = 16'h0000;
  logic [7:0]  gap_pat = 8'b1001_0110;

  noise_table_loader #(.AW(12), .DW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .busy(busy), .done(done), .table_valid(table_valid),
    .load_count(load_count), .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write must match the oldest expected write, including the done flag.
  always @(negedge clk) begin
    logic [20:0] e;
    if (ram_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {19'd0, ram_addr, 1'b1}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 32'(ram_addr), 32'(e[19:8]));
        check("write_data", 32'(ram_din), 32'(e[7:0]));
        check("write_done", 32'(done), 32'(e[20]));
      end
    end else if (done === 1'b1) begin
      check("done_without_write", 32'(done), 32'h0);
    end
  end

  task automatic beat(input logic [7:0] d, input logic v);
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; din = d; din_valid = v;
    #3;
    check("din_ready", 32'(din_ready), 32'(mloading));
    if (v && mloading) begin
      exp_q.push_back({mcount == 4095, mcount[11:0], d});
      mcount++;
      mcs += 16'(d);
      if (mcount == 4096) mloading = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b0; din = 8'h55; din_valid = 1'b1;
    #3;
    check("din_ready_in_start", 32'(din_ready), 32'h0);
    mloading = 1'b1; mcount = 0; mcs = 16'h0000;
  endtask

  task automatic pulse_abort();
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b1; din = 8'h66; din_valid = 1'b1;
    #3;
    check("din_ready_in_abort", 32'(din_ready), 32'h0);
    mloading = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0; abort = 1'b0; din_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mloading = 1'b0;
    check("rst_ram_we", 32'(ram_we), 32'h0);
    check("rst_ram_addr", 32'(ram_addr), 32'h0);
    check("rst_ram_din", 32'(ram_din), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_table_valid", 32'(table_valid), 32'h0);
    check("rst_load_count", 32'(load_count), 32'h0);
    check("rst_checksum", 32'(checksum), 32'h0);
    check("rst_din_ready", 32'(din_ready), 32'h0);
  endtask

  task automatic load_full(input logic gaps);
    int k = 0;
    while (mloading) begin
      logic v;
      v = gaps ? gap_pat[k % 8] : 1'b1;
      beat(v ? 8'(mcount) : 8'hAA, v);
      k++;
    end
  endtask

  // Checks the DONE cycle and the IDLE cycle after it for a 0..4095 ramp table.
  task automatic check_completion();
    @(posedge clk); #1;
    check("done_cycle_done", 32'(done), 32'h1);
    check("done_cycle_busy", 32'(busy), 32'h1);
    check("done_cycle_count", 32'(load_count), 32'd4096);
    check("done_cycle_checksum", 32'(checksum), 32'hF800);
    check("done_cycle_tv", 32'(table_valid), 32'h0);
    @(posedge clk); #1;
    check("after_done_tv", 32'(table_valid), 32'h1);
    check("after_done_done", 32'(done), 32'h0);
    check("after_done_busy", 32'(busy), 32'h0);
    check("after_done_ready", 32'(din_ready), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();

    // Full load without stalls.
    pulse_start();
    load_full(1'b0);
    check("model_checksum_full", 32'(mcs), 32'hF800);
    check_completion();

    // Full load with gaps.
    pulse_start();
    beat(8'h00, 1'b0);
    check("start_clears_tv", 32'(table_valid), 32'h0);
    check("start_busy", 32'(busy), 32'h1);
    load_full(1'b1);
    check_completion();

    // Abort after 100 beats.
    pulse_start();
    repeat (100) beat(8'(mcount), 1'b1);
    pulse_abort();
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_ready", 32'(din_ready), 32'h0);
    check("abort_tv", 32'(table_valid), 32'h0);
    check("abort_count", 32'(load_count), 32'd100);
    check("abort_checksum", 32'(checksum), 32'h1356);
    check("abort_busy", 32'(busy), 32'h0);
    repeat (3) beat(8'h77, 1'b1);

    // Restart after 500 beats, then a full new table.
    pulse_start();
    repeat (500) beat(8'(mcount), 1'b1);
    pulse_start();
    load_full(1'b0);
    check_completion();

    // Start on the DONE cycle.
    pulse_start();
    load_full(1'b0);
    pulse_start();
    beat(8'h11, 1'b1);
    check("restart_tv", 32'(table_valid), 32'h0);
    check("restart_count", 32'(load_count), 32'h0);
    check("restart_busy", 32'(busy), 32'h1);
    beat(8'h22, 1'b1);
    pulse_abort();
    @(posedge clk); #1;
    abort = 1'b0;
    check("restart_abort_count", 32'(load_count), 32'd2);
    check("restart_abort_checksum", 32'(checksum), 32'h0033);

    // Reset after 10 beats; start needed before din_ready rises.
    pulse_start();
    repeat (10) beat(8'(mcount), 1'b1);
    do_reset();
    repeat (3) beat(8'h33, 1'b1);

    din_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
